// File: rtl/spi_fb_pkg.sv
// Shared definitions for the SPI framebuffer command decoder:
// opcodes, decoder state encoding and status/error bit positions.
package spi_fb_pkg;

  // First byte of every CS-framed transaction
  localparam logic [7:0] OP_PIXEL  = 8'h01;
  localparam logic [7:0] OP_BURST  = 8'h02;
  localparam logic [7:0] OP_FILL   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_PIXEL,
    ST_BURST,
    ST_FILL_COLOR,
    ST_FILL,
    ST_DISCARD
  } state_e;

  // Sticky error flag positions within err[2:0]
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_RANGE   = 0;
  localparam int unsigned ERR_OVERRUN = 1;
  localparam int unsigned ERR_OPCODE  = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with a configurable reset value.
module cdc_sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input into the chain, oldest sample at the MSB
  always_comb begin
    sync_d = STAGES'({sync_q, d});
  end

  // Synchronizer flops, preset to RST_VAL on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_fb_cmd_decoder.sv
// Decodes the SPI slave's received-byte stream into framebuffer write
// cycles (single pixel, auto-increment burst, full-screen fill) and
// returns a registered status byte for the SPI transmit path.
module spi_fb_cmd_decoder
  import spi_fb_pkg::*;
#(
  parameter int unsigned FB_DEPTH = 19200,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned CS_SYNC  = 4
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [PIX_W-1:0]  rx_data,
  output logic [PIX_W-1:0]  tx_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_wdata,
  output logic              busy,
  output logic [ERR_W-1:0]  err,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  logic cs_sync;
  logic cs_prev_q, cs_prev_d;
  logic frame_end;

  state_e            state_q, state_d;
  logic              is_burst_q, is_burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]  fb_wdata_q, fb_wdata_d;
  logic              busy_q, busy_d;
  logic [ERR_W-1:0]  err_q, err_d, err_set;
  logic [PIX_W-1:0]  tx_q, tx_d;
  logic              in_range;

  cdc_sync_bit #(
    .STAGES  (CS_SYNC),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk (sclk),
    .rst (rst),
    .d   (cs_n),
    .q   (cs_sync)
  );

  // Detect the rising edge of the synchronized chip select
  always_comb begin
    cs_prev_d = cs_sync;
    frame_end = cs_sync & ~cs_prev_q;
  end

  assign in_range = ({1'b0, addr_q} < DEPTH_X);

  // Command decode, address counter and write/status generation
  always_comb begin
    state_d    = state_q;
    is_burst_d = is_burst_q;
    addr_d     = addr_q;
    color_d    = color_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    busy_d     = 1'b0;
    err_set    = '0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            PIX_W'(OP_PIXEL): begin
              is_burst_d = 1'b0;
              state_d    = ST_ADDR_HI;
            end
            PIX_W'(OP_BURST): begin
              is_burst_d = 1'b1;
              state_d    = ST_ADDR_HI;
            end
            PIX_W'(OP_FILL):   state_d = ST_FILL_COLOR;
            PIX_W'(OP_STATUS): state_d = ST_DISCARD;
            default: begin
              err_set[ERR_OPCODE] = 1'b1;
              state_d             = ST_DISCARD;
            end
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (rx_valid) begin
          addr_d  = ADDR_W'({rx_data[7:0], 8'h00});
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_valid) begin
          addr_d  = {addr_q[ADDR_W-1:8], rx_data[7:0]};
          state_d = is_burst_q ? ST_BURST : ST_PIXEL;
        end
      end
      ST_PIXEL, ST_BURST: begin
        if (rx_valid) begin
          if (in_range) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = addr_q;
            fb_wdata_d = rx_data;
          end else begin
            err_set[ERR_RANGE] = 1'b1;
          end
          if (state_q == ST_PIXEL) begin
            state_d = ST_DISCARD;
          end else begin
            // Out-of-range addresses keep counting and wrap naturally at 2**ADDR_W
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          end
        end
      end
      ST_FILL_COLOR: begin
        if (rx_valid) begin
          color_d = rx_data;
          addr_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        fb_we_d    = 1'b1;
        busy_d     = 1'b1;
        fb_addr_d  = addr_q;
        fb_wdata_d = color_q;
        if (rx_valid) err_set[ERR_OVERRUN] = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          // The fill ignored frame_end, so use the CS level to decide
          // whether the rest of the current frame must be discarded.
          state_d = cs_sync ? ST_IDLE : ST_DISCARD;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DISCARD: ;
      default: state_d = ST_IDLE;
    endcase

    if (frame_end && (state_q != ST_FILL)) state_d = ST_IDLE;

    err_d = (clr_err ? '0 : err_q) | err_set;

    tx_d = '0;
    tx_d[PIX_W-1 -: 4] = {busy_d, err_d};
  end

  // State and output registers
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cs_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      is_burst_q <= 1'b0;
      addr_q     <= '0;
      color_q    <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= '0;
      tx_q       <= '0;
    end else begin
      cs_prev_q  <= cs_prev_d;
      state_q    <= state_d;
      is_burst_q <= is_burst_d;
      addr_q     <= addr_d;
      color_q    <= color_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tx_q       <= tx_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign tx_data  = tx_q;

endmodule

// File: tb/tb_spi_fb_cmd_decoder.sv
// Directed testbench for spi_fb_cmd_decoder.
module tb_spi_fb_cmd_decoder;

  logic        sclk;
  logic        rst;
  logic        cs_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        busy;
  logic [2:0]  err;
  logic        clr_err;

  int total = 0;
  int bad   = 0;

  int         wq_addr[$];
  logic [7:0] wq_data[$];
  int         busy_cnt;
  int         busy_we_diff;

  spi_fb_cmd_decoder #(
    .FB_DEPTH (19200),
    .ADDR_W   (15),
    .PIX_W    (8),
    .CS_SYNC  (4)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .cs_n     (cs_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .busy     (busy),
    .err      (err),
    .clr_err  (clr_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Record framebuffer writes and busy activity, sampled mid-cycle
  always @(negedge sclk) begin
    if (rst === 1'b0) begin
      if (fb_we === 1'b1) begin
        wq_addr.push_back(int'(fb_addr));
        wq_data.push_back(fb_wdata);
      end
      if (busy === 1'b1) busy_cnt++;
      if (busy !== fb_we) busy_we_diff++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge sclk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge sclk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge sclk);
    cs_n = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge sclk);
    cs_n = 1'b1;
    repeat (8) @(negedge sclk);
  endtask

  task automatic pulse_clr();
    @(negedge sclk);
    clr_err = 1'b1;
    @(negedge sclk);
    clr_err = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    busy_cnt     = 0;
    busy_we_diff = 0;
  endtask

  task automatic test_reset();
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", fb_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx: got %h want 00", tx_data); end
    total++; if (fb_addr !== 15'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", fb_addr); end
    @(negedge sclk);
    rst = 1'b0;
    repeat (6) @(negedge sclk);
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL idle_we: got %b want 0", fb_we); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL idle_tx: got %h want 00", tx_data); end
  endtask

  task automatic test_pixel();
    clear_log();
    start_frame();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h2C);
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL pixel_early: got %b want 0", fb_we); end
    send_byte(8'hE0);
    total++; if (fb_we !== 1'b1) begin bad++; $display("FAIL pixel_we: got %b want 1", fb_we); end
    total++; if (fb_addr !== 15'd300) begin bad++; $display("FAIL pixel_addr: got %0d want 300", fb_addr); end
    total++; if (fb_wdata !== 8'hE0) begin bad++; $display("FAIL pixel_data: got %h want e0", fb_wdata); end
    @(negedge sclk);
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL pixel_one_cycle: got %b want 0", fb_we); end
    end_frame();
    total++; if (wq_addr.size() != 1) begin bad++; $display("FAIL pixel_count: got %0d want 1", wq_addr.size()); end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL pixel_err: got %b want 000", err); end
  endtask

  task automatic test_burst();
    clear_log();
    start_frame();
    send_byte(8'h02);
    send_byte(8'h4A);
    send_byte(8'hFE);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    end_frame();
    total++;
    if (wq_addr.size() != 3) begin
      bad++; $display("FAIL burst_count: got %0d want 3", wq_addr.size());
    end else begin
      if (wq_addr[0] != 19198 || wq_data[0] !== 8'h11) begin bad++; $display("FAIL burst_w0: got %0d<=%h want 19198<=11", wq_addr[0], wq_data[0]); end
      total++;
      if (wq_addr[1] != 19199 || wq_data[1] !== 8'h22) begin bad++; $display("FAIL burst_w1: got %0d<=%h want 19199<=22", wq_addr[1], wq_data[1]); end
      total++;
      if (wq_addr[2] != 0 || wq_data[2] !== 8'h33) begin bad++; $display("FAIL burst_wrap: got %0d<=%h want 0<=33", wq_addr[2], wq_data[2]); end
    end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL burst_err: got %b want 000", err); end
  endtask

  task automatic test_fill();
    int n;
    int seq_bad;
    clear_log();
    start_frame();
    send_byte(8'h03);
    send_byte(8'h1C);
    repeat (500) @(negedge sclk);
    send_byte(8'h99);
    @(negedge sclk);
    cs_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 25000) begin
      @(negedge sclk);
      n++;
    end
    total++; if (n >= 25000) begin bad++; $display("FAIL fill_timeout: got busy=%b after %0d cycles want 0", busy, n); end
    repeat (2) @(negedge sclk);
    total++; if (wq_addr.size() != 19200) begin bad++; $display("FAIL fill_count: got %0d want 19200", wq_addr.size()); end
    seq_bad = 0;
    foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== 8'h1C) seq_bad++;
    total++; if (seq_bad != 0) begin bad++; $display("FAIL fill_seq: got %0d bad writes want 0", seq_bad); end
    total++; if (busy_cnt != 19200) begin bad++; $display("FAIL fill_busy_len: got %0d want 19200", busy_cnt); end
    total++; if (busy_we_diff != 0) begin bad++; $display("FAIL fill_busy_align: got %0d cycles want 0", busy_we_diff); end
    total++; if (err !== 3'b010) begin bad++; $display("FAIL fill_overrun: got %b want 010", err); end
    total++; if (tx_data !== 8'h20) begin bad++; $display("FAIL fill_tx: got %h want 20", tx_data); end
    pulse_clr();
    total++; if (err !== 3'b000) begin bad++; $display("FAIL fill_clr: got %b want 000", err); end
  endtask

  task automatic test_range();
    clear_log();
    start_frame();
    send_byte(8'h01);
    send_byte(8'h4B);
    send_byte(8'h00);
    send_byte(8'h55);
    end_frame();
    total++; if (wq_addr.size() != 0) begin bad++; $display("FAIL range_nowrite: got %0d writes want 0", wq_addr.size()); end
    total++; if (err !== 3'b001) begin bad++; $display("FAIL range_err: got %b want 001", err); end
    total++; if (tx_data !== 8'h10) begin bad++; $display("FAIL range_tx: got %h want 10", tx_data); end
    pulse_clr();
    total++; if (err !== 3'b000) begin bad++; $display("FAIL range_clr: got %b want 000", err); end
    start_frame();
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL range_next_tx: got %h want 00", tx_data); end
    send_byte(8'h04);
    end_frame();
  endtask

  task automatic test_opcode_and_partial();
    clear_log();
    start_frame();
    send_byte(8'h07);
    send_byte(8'hAA);
    end_frame();
    total++; if (err !== 3'b100) begin bad++; $display("FAIL opcode_err: got %b want 100", err); end
    total++; if (tx_data !== 8'h40) begin bad++; $display("FAIL opcode_tx: got %h want 40", tx_data); end
    total++; if (wq_addr.size() != 0) begin bad++; $display("FAIL opcode_nowrite: got %0d want 0", wq_addr.size()); end
    pulse_clr();
    start_frame();
    send_byte(8'h01);
    send_byte(8'h00);
    end_frame();
    start_frame();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h77);
    end_frame();
    total++;
    if (wq_addr.size() != 1) begin
      bad++; $display("FAIL partial_count: got %0d want 1", wq_addr.size());
    end else if (wq_addr[0] != 5 || wq_data[0] !== 8'h77) begin
      bad++; $display("FAIL partial_write: got %0d<=%h want 5<=77", wq_addr[0], wq_data[0]);
    end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL partial_err: got %b want 000", err); end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    clear_log();
    start_frame();
    send_byte(8'h03);
    send_byte(8'h3C);
    repeat (100) @(negedge sclk);
    send_byte(8'h5A);
    n = 0;
    while (!(fb_we === 1'b1 && fb_addr === 15'd1000) && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    total++; if (n >= 3000) begin bad++; $display("FAIL rstfill_timeout: got addr %0d want 1000", fb_addr); end
    total++; if (err !== 3'b010 || busy !== 1'b1) begin bad++; $display("FAIL rstfill_pre: got err=%b busy=%b want 010/1", err, busy); end
    #2 rst = 1'b1;
    #1;
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL rstfill_we: got %b want 0", fb_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfill_busy: got %b want 0", busy); end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL rstfill_err: got %b want 000", err); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rstfill_tx: got %h want 00", tx_data); end
    @(negedge sclk);
    cs_n = 1'b1;
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    clear_log();
    repeat (20) @(negedge sclk);
    total++; if (wq_addr.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rstfill_stopped: got %0d writes busy=%b want 0/0", wq_addr.size(), busy); end
    start_frame();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h07);
    send_byte(8'hA5);
    end_frame();
    total++;
    if (wq_addr.size() != 1) begin
      bad++; $display("FAIL rstfill_idle: got %0d writes want 1", wq_addr.size());
    end else if (wq_addr[0] != 7 || wq_data[0] !== 8'hA5) begin
      bad++; $display("FAIL rstfill_idle_write: got %0d<=%h want 7<=a5", wq_addr[0], wq_data[0]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clr_err  = 1'b0;
    clear_log();
    repeat (3) @(negedge sclk);
    test_reset();
    test_pixel();
    test_burst();
    test_fill();
    test_range();
    test_opcode_and_partial();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
